// File: rtl/noc_pkg.sv
// Shared NoC types: serializer state encoding and default packet/link widths.
package noc_pkg;

  localparam int PKT_WIDTH  = 128;
  localparam int LINK_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    CSUM = 2'd2
  } ser_state_t;

endpackage

// File: rtl/packet_serializer_if.sv
// Wide-packet-in / narrow-beat-out handshake bundle around the serializer.
// master = upstream FIFO plus link side driving the serializer; slave = the serializer.
interface packet_serializer_if
  import noc_pkg::*;
#(
  parameter int IN_WIDTH  = PKT_WIDTH,
  parameter int OUT_WIDTH = LINK_WIDTH
);

  logic [IN_WIDTH-1:0]  in_element;
  logic                 in_valid;
  logic                 in_ready;
  logic [OUT_WIDTH-1:0] out_beat;
  logic                 out_valid;
  logic                 out_last;
  logic                 out_ready;
  logic                 busy;

  modport master (
    output in_element, in_valid, out_ready,
    input  in_ready, out_beat, out_valid, out_last, busy
  );

  modport slave (
    input  in_element, in_valid, out_ready,
    output in_ready, out_beat, out_valid, out_last, busy
  );

endinterface

// File: rtl/packet_serializer.sv
// Splits one wide packet into LSB-first narrow beats plus an optional XOR checksum beat.
// First beat one cycle after input handshake; beats hold under out_ready=0; reloads with no bubble.
module packet_serializer
  import noc_pkg::*;
#(
  parameter int IN_WIDTH        = PKT_WIDTH,
  parameter int OUT_WIDTH       = LINK_WIDTH,
  parameter bit APPEND_CHECKSUM = 1'b1
) (
  input logic                clk,
  input logic                rst_n,
  packet_serializer_if.slave bus
);

  localparam int NUM_BEATS = IN_WIDTH / OUT_WIDTH;
  localparam int CNT_W     = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_BEATS - 1);
  localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(NUM_BEATS - 2);

  if ((IN_WIDTH % OUT_WIDTH) != 0 || NUM_BEATS < 2) begin : g_bad_widths
    $error("packet_serializer: IN_WIDTH must be a multiple of OUT_WIDTH with at least 2 beats");
  end

  ser_state_t           state;
  logic [CNT_W-1:0]     beat_cnt;
  logic [OUT_WIDTH-1:0] csum;
  logic [IN_WIDTH-1:0]  data;
  logic                 out_valid_q;
  logic                 out_last_q;
  logic [OUT_WIDTH-1:0] cur_beat;
  logic                 beat_acc;
  logic                 in_ready_c;
  logic                 load;

  assign cur_beat   = (state == CSUM) ? csum : data[int'(beat_cnt)*OUT_WIDTH +: OUT_WIDTH];
  assign beat_acc   = out_valid_q & bus.out_ready;
  // Combinational through out_ready so the next packet loads in the final-beat cycle.
  assign in_ready_c = (state == IDLE) | (beat_acc & out_last_q);
  assign load       = bus.in_valid & in_ready_c;

  assign bus.in_ready  = in_ready_c;
  assign bus.out_beat  = cur_beat;
  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = out_last_q;
  assign bus.busy      = (state != IDLE);

  always_ff @(posedge clk) begin
    if (load) data <= bus.in_element;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      beat_cnt    <= '0;
      csum        <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: ;
        SEND: begin
          if (bus.out_ready) begin
            csum <= csum ^ cur_beat;
            if (beat_cnt == LAST_CNT) begin
              if (APPEND_CHECKSUM) begin
                state      <= CSUM;
                out_last_q <= 1'b1;
              end else begin
                state       <= IDLE;
                out_valid_q <= 1'b0;
                out_last_q  <= 1'b0;
              end
            end else begin
              beat_cnt   <= beat_cnt + 1'b1;
              out_last_q <= !APPEND_CHECKSUM && (beat_cnt == PRE_LAST);
            end
          end
        end
        CSUM: begin
          if (bus.out_ready) begin
            state       <= IDLE;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
          end
        end
        default: begin
          state       <= IDLE;
          out_valid_q <= 1'b0;
          out_last_q  <= 1'b0;
        end
      endcase
      // A handshake overrides the final-beat wind-down above, giving gapless reload.
      if (load) begin
        state       <= SEND;
        beat_cnt    <= '0;
        csum        <= '0;
        out_valid_q <= 1'b1;
        out_last_q  <= 1'b0;
      end
    end
  end

endmodule
